// File: rtl/disp_mux_pwm.sv
// -----------------------------------------------------------------------------
// disp_mux_pwm
//   Time-multiplexed seven-segment driver for N_DIGITS common-anode digits.
//   Keeps its own per-digit segment pattern registers (loaded via an indexed
//   write port), scans one digit per refresh slot, and gates the active digit
//   with per-digit blanking and a PWM brightness control.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous reset, active-high
//   wr_en      in   write strobe for one digit pattern register
//   wr_sel     in   digit index to write; indices >= N_DIGITS are ignored
//   wr_data    in   segment pattern, active-low {dp,g,f,e,d,c,b,a}
//   blank_mask in   per-digit blank; 1 forces that digit dark
//   duty       in   brightness; 0 = dark, all-ones = always on
//   an         out  anode enables, active-low, registered (at most one low)
//   sseg       out  segment drives, active-low, registered
// -----------------------------------------------------------------------------
module disp_mux_pwm #(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_BITS = 18,
    parameter int PWM_BITS     = 4,
    localparam int SELW        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [SELW-1:0]         wr_sel,
    input  logic [7:0]              wr_data,
    input  logic [N_DIGITS-1:0]     blank_mask,
    input  logic [PWM_BITS-1:0]     duty,
    output logic [N_DIGITS-1:0]     an,
    output logic [7:0]              sseg
);

    localparam logic [N_DIGITS-1:0] AN_ONE   = N_DIGITS'(1);
    localparam logic [SELW-1:0]     IDX_LAST = SELW'(N_DIGITS - 1);

    // Refresh counter and current digit index
    logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
    logic [SELW-1:0]         idx_q, idx_d;

    // Registered outputs
    logic [N_DIGITS-1:0]     an_q, an_d;
    logic [7:0]              sseg_q, sseg_d;

    // Flattened view of all digit pattern registers
    logic [N_DIGITS-1:0][7:0] digits;

    // One pattern register per digit. Comparing against the constant digit
    // number means an index >= N_DIGITS matches no register and is dropped.
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            logic [7:0] d_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    d_q <= 8'hFF;
                end else if (wr_en && (wr_sel == SELW'(gi))) begin
                    d_q <= wr_data;
                end
            end

            assign digits[gi] = d_q;
        end
    endgenerate

    // Slot advance happens on the same edge the counter wraps to zero.
    always_comb begin
        cnt_d = cnt_q + REFRESH_BITS'(1);
        idx_d = idx_q;
        if (cnt_q == {REFRESH_BITS{1'b1}}) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + SELW'(1);
        end
    end

    // PWM phase is the top bits of the slot counter, so each slot is split
    // into 2**PWM_BITS equal sub-periods. Full-scale duty is special-cased
    // because phase < duty can never hold for the last sub-period.
    logic [PWM_BITS-1:0] phase;
    logic                lit;
    logic                show;

    assign phase = cnt_q[REFRESH_BITS-1 -: PWM_BITS];
    assign lit   = (duty == {PWM_BITS{1'b1}}) || (phase < duty);
    assign show  = lit && !blank_mask[idx_q];

    // Segments are only driven together with their anode; when dark both
    // go inactive so no ghosting appears on another digit.
    always_comb begin
        an_d   = '1;
        sseg_d = 8'hFF;
        if (show) begin
            an_d   = ~(AN_ONE << idx_q);
            sseg_d = digits[idx_q];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            an_q   <= '1;
            sseg_q <= 8'hFF;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            sseg_q <= sseg_d;
        end
    end

    assign an   = an_q;
    assign sseg = sseg_q;

endmodule

// File: tb/tb_disp_mux_pwm.sv
// -----------------------------------------------------------------------------
// tb_disp_mux_pwm
//   Bench for disp_mux_pwm with 16-cycle slots (REFRESH_BITS=4, PWM_BITS=2).
//   Every driven cycle pushes the expected {an,sseg} into a queue; a monitor
//   on the falling edge pops and compares. Directed spot checks with
//   hand-written values run alongside. A second, 5-digit instance covers an
//   out-of-range write index, which a 2-bit select cannot express.
// -----------------------------------------------------------------------------
module tb_disp_mux_pwm;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [1:0] wr_sel;
    logic [7:0] wr_data;
    logic [3:0] blank_mask;
    logic [1:0] duty;
    logic [3:0] an;
    logic [7:0] sseg;

    logic       wr_en5;
    logic [2:0] wr_sel5;
    logic [4:0] an5;
    logic [7:0] sseg5;

    always #5 clk = ~clk;

    disp_mux_pwm #(.N_DIGITS(4), .REFRESH_BITS(4), .PWM_BITS(2)) u_dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_data(wr_data), .blank_mask(blank_mask), .duty(duty),
        .an(an), .sseg(sseg)
    );

    disp_mux_pwm #(.N_DIGITS(5), .REFRESH_BITS(4), .PWM_BITS(2)) u_dut5 (
        .clk(clk), .reset(reset), .wr_en(wr_en5), .wr_sel(wr_sel5),
        .wr_data(wr_data), .blank_mask(5'b00000), .duty(duty),
        .an(an5), .sseg(sseg5)
    );

    typedef struct {
        int         t;
        logic [3:0] an;
        logic [7:0] sseg;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_d [4];
    int         t_cyc;
    int         n_tests = 0;
    int         n_fail  = 0;

    // Monitor: outputs registered on the rising edge are compared on the
    // following falling edge.
    always @(negedge clk) begin
        if (!reset && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            if (an !== e.an || sseg !== e.sseg) begin
                n_fail++;
                $display("FAIL scoreboard t=%0d: got an=%b sseg=%h, expected an=%b sseg=%h",
                         e.t, an, sseg, e.an, e.sseg);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %h", name, act);
        end
    endtask

    // One clock of stimulus: the expected output for the coming edge is
    // derived from the elapsed cycle count (slot = t/16, sub-period = t%16/4)
    // and the inputs currently applied, then the edge is taken.
    task automatic step();
        exp_t e;
        int   cnt, idx, phase;
        bit   lit, show;
        cnt   = t_cyc % 16;
        idx   = (t_cyc / 16) % 4;
        phase = cnt / 4;
        lit   = (duty == 2'd3) || (phase < int'(duty));
        show  = lit && !blank_mask[idx];
        e.t    = t_cyc;
        e.an   = show ? ~(4'b0001 << idx) : 4'b1111;
        e.sseg = show ? exp_d[idx] : 8'hFF;
        exp_q.push_back(e);
        if (wr_en) exp_d[wr_sel] = wr_data;
        t_cyc++;
        @(negedge clk);
        #2;
    endtask

    // Advance at least one cycle until the latest output belongs to the given
    // slot and counter position.
    task automatic goto(input int slot, input int pos);
        int guard = 0;
        do begin
            step();
            guard++;
        end while (!((((t_cyc - 1) / 16) % 4 == slot) && ((t_cyc - 1) % 16 == pos)) && guard < 200);
        if (guard >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL goto timeout: slot %0d pos %0d not reached", slot, pos);
        end
    endtask

    task automatic write(input logic [1:0] sel, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_data = data;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        t_cyc = 0;
        for (int i = 0; i < 4; i++) exp_d[i] = 8'hFF;
    endtask

    logic [3:0] an_tab [4];

    initial begin
        int lit5;

        an_tab[0] = 4'b1110; an_tab[1] = 4'b1101;
        an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;

        reset = 1'b0; wr_en = 1'b0; wr_sel = 2'd0; wr_data = 8'h00;
        blank_mask = 4'b0000; duty = 2'd3; wr_en5 = 1'b0; wr_sel5 = 3'd0;
        model_reset();

        // Reset takes effect before any clock edge
        #3 reset = 1'b1;
        #1;
        check("reset_an", 32'(an), 32'hF);
        check("reset_sseg", 32'(sseg), 32'hFF);
        @(negedge clk); #2;
        reset = 1'b0;

        // 1: no writes, full duty: anode scans, segments stay FF
        for (int k = 0; k < 4; k++) begin
            goto(k, 8);
            check($sformatf("scan_an_slot%0d", k), 32'(an), 32'(an_tab[k]));
            check($sformatf("scan_sseg_slot%0d", k), 32'(sseg), 32'hFF);
        end

        // 2: load patterns, full frame
        write(2'd0, 8'hC0);
        write(2'd1, 8'hF9);
        write(2'd2, 8'hA4);
        write(2'd3, 8'hB0);
        goto(1, 8);
        check("d1_an", 32'(an), 32'b1101);
        check("d1_sseg", 32'(sseg), 32'hF9);
        goto(3, 3);
        check("d3_an", 32'(an), 32'b0111);
        check("d3_sseg", 32'(sseg), 32'hB0);
        goto(0, 15);
        check("d0_sseg", 32'(sseg), 32'hC0);
        goto(2, 0);
        check("d2_sseg", 32'(sseg), 32'hA4);

        // 3: reduced brightness
        duty = 2'd2;
        goto(0, 7);
        check("duty2_lit_an", 32'(an), 32'b1110);
        goto(0, 8);
        check("duty2_dark_an", 32'(an), 32'hF);
        check("duty2_dark_sseg", 32'(sseg), 32'hFF);
        duty = 2'd1;
        goto(1, 3);
        check("duty1_lit_an", 32'(an), 32'b1101);
        goto(1, 4);
        check("duty1_dark_an", 32'(an), 32'hF);
        duty = 2'd0;
        goto(2, 0);
        check("duty0_an", 32'(an), 32'hF);
        goto(2, 15);
        check("duty0_sseg", 32'(sseg), 32'hFF);

        // 4: blank digit 2 only
        duty = 2'd3;
        blank_mask = 4'b0100;
        goto(2, 5);
        check("blank2_an", 32'(an), 32'hF);
        check("blank2_sseg", 32'(sseg), 32'hFF);
        goto(3, 5);
        check("blank_other_an", 32'(an), 32'b0111);
        check("blank_other_sseg", 32'(sseg), 32'hB0);
        blank_mask = 4'b0000;

        // 5a: write to the digit on display shows up two clocks later
        goto(1, 3);
        check("pre_write_sseg", 32'(sseg), 32'hF9);
        write(2'd1, 8'h92);
        check("write_plus1_sseg", 32'(sseg), 32'hF9);
        step();
        check("write_plus2_sseg", 32'(sseg), 32'h92);

        // 5b: out-of-range index on the 5-digit instance is ignored
        wr_en5  = 1'b1;
        wr_sel5 = 3'd5;
        wr_data = 8'h00;
        step();
        wr_en5  = 1'b0;
        lit5 = 0;
        for (int c = 0; c < 80; c++) begin
            step();
            check($sformatf("oor_sseg5_c%0d", c), 32'(sseg5), 32'hFF);
            if (an5 != 5'h1F) lit5++;
        end
        check("oor_an5_active_cycles", 32'(lit5), 32'd80);

        // 6: reset mid-slot 2 clears outputs at once and wipes digits
        goto(2, 6);
        check("pre_reset_an", 32'(an), 32'b1011);
        #1 reset = 1'b1;
        #1;
        check("midreset_an", 32'(an), 32'hF);
        check("midreset_sseg", 32'(sseg), 32'hFF);
        model_reset();
        @(negedge clk); #2;
        reset = 1'b0;
        step();
        check("post_reset_an", 32'(an), 32'b1110);
        check("post_reset_sseg", 32'(sseg), 32'hFF);
        for (int k = 0; k < 4; k++) begin
            goto(k, 10);
            check($sformatf("post_reset_d%0d", k), 32'(sseg), 32'hFF);
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
